// File: rtl/dbus_responder_pkg.sv
// Shared types and constants for the dbus_responder data-bus slave memory.
// Bus request/response layouts used by the core's memory stage.
package dbus_responder_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      WAIT,
      RESP
   } state_e;

   localparam int          CNT_W     = 4;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dbus_responder_if.sv
// Data-bus request/response bundle between the core (master)
// and a memory responder (slave).
interface dbus_responder_if;
   import dbus_responder_pkg::*;

   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_resp_lfsr.sv
// 16-bit Galois LFSR for response-delay jitter; only built when
// DBUS_RESP_RANDOM_DELAY_EN is defined.
`ifdef DBUS_RESP_RANDOM_DELAY_EN
module dbus_resp_lfsr
   import dbus_responder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] lfsr
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign lfsr = lfsr_q;

endmodule
`endif

// File: rtl/dbus_responder.sv
// Word-addressed RAM slave with addr_ok/data_ok handshake and fixed latency.
// Optional LFSR delay jitter enabled by DBUS_RESP_RANDOM_DELAY_EN.
module dbus_responder
   import dbus_responder_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   dbus_responder_if.slave              bus,
   input  logic                         load_en,
   input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
   input  logic [31:0]                  load_data,
   output logic                         busy
);

   localparam int IW = $clog2(MEM_WORDS);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [3:0]        strb_q, strb_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  extra;
   logic [CNT_W:0]    load_sum;
   logic [CNT_W-1:0]  cnt_load;
   dbus_resp_t        resp;
   logic              unused_ok;

   logic [3:0][7:0]   mem [MEM_WORDS];

`ifdef DBUS_RESP_RANDOM_DELAY_EN
   logic [15:0] lfsr;

   dbus_resp_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .lfsr  (lfsr)
   );

   assign extra = {{(CNT_W-2){1'b0}}, lfsr[1:0]};
`else
   assign extra = '0;
`endif

   // Jitter saturates rather than wrapping the 4-bit counter
   assign load_sum = (CNT_W+1)'(LATENCY - 1) + {1'b0, extra};
   assign cnt_load = load_sum[CNT_W] ? '1 : load_sum[CNT_W-1:0];

   assign unused_ok = ^{bus.dreq.size,
                        bus.dreq.addr[31:IW+2],
                        bus.dreq.addr[1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      strb_d  = strb_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.dreq.valid) begin
               idx_d   = bus.dreq.addr[IW+1:2];
               strb_d  = bus.dreq.strobe;
               wdata_d = bus.dreq.data;
               state_d = ACCEPT;
            end
         end
         ACCEPT: begin
            cnt_d   = cnt_load;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         strb_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         strb_q  <= strb_d;
         wdata_q <= wdata_d;
      end
   end

   // Response write is issued last so it overrides a same-edge backdoor load
   always_ff @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
      if (state_q == RESP) begin
         for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) mem[idx_q][b] <= wdata_q[8*b +: 8];
         end
      end
   end

   always_comb begin
      resp         = '0;
      resp.addr_ok = (state_q == ACCEPT);
      resp.data_ok = (state_q == RESP);
      if (state_q == RESP && strb_q == '0) resp.data = mem[idx_q];
   end

   assign bus.dresp = resp;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dbus_responder.sv
// Directed self-checking bench for dbus_responder.
// Covers reset, reads, byte-strobed writes, wrap, abort and backdoor priority.
module tb_dbus_responder;
   import dbus_responder_pkg::*;

   localparam int MEM_WORDS = 1024;
   localparam int LATENCY   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [9:0]  load_addr;
   logic [31:0] load_data;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int n_aok = 0;
   int n_dok = 0;
   int nreq  = 0;

   dbus_responder_if bus ();

   dbus_responder #(
      .MEM_WORDS (MEM_WORDS),
      .LATENCY   (LATENCY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.dresp.addr_ok) n_aok++;
      if (bus.dresp.data_ok) n_dok++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic backdoor(input logic [9:0] i, input logic [31:0] d);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = i;
      load_data = d;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   task automatic xfer(input string tag, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input logic [31:0] exp);
      int n;
      int k;
      int extra_aok;
      int busy_lo;
      @(negedge clk);
      bus.dreq.valid  = 1'b1;
      bus.dreq.addr   = a;
      bus.dreq.size   = 3'd2;
      bus.dreq.strobe = s;
      bus.dreq.data   = d;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.dresp.addr_ok) break;
      end
      chk({tag, "/aok_lat"}, n, 0);
      extra_aok = 0;
      busy_lo   = 0;
      for (k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.dresp.data_ok) break;
         if (bus.dresp.addr_ok) extra_aok++;
         if (!busy) busy_lo++;
      end
`ifdef DBUS_RESP_RANDOM_DELAY_EN
      chk({tag, "/dok_lat_range"},
          32'((k >= LATENCY + 1) && (k <= LATENCY + 4)), 1);
`else
      chk({tag, "/dok_lat"}, k, LATENCY + 1);
`endif
      chk({tag, "/data"}, bus.dresp.data, exp);
      chk({tag, "/aok_dup_busy"}, {extra_aok[15:0], busy_lo[15:0]}, 0);
      bus.dreq = '0;
      nreq++;
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      bus.dreq  = '0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset/flags", {bus.dresp.addr_ok, bus.dresp.data_ok, busy}, 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle/data", bus.dresp.data, 0);
         chk("idle/flags", {bus.dresp.addr_ok, bus.dresp.data_ok, busy}, 0);
      end

      backdoor(10'd4, 32'hDEADBEEF);
      xfer("rd_bd", 32'h10, 4'b0000, 32'h0, 32'hDEADBEEF);
      xfer("wr_lo", 32'h10, 4'b0011, 32'h12345678, 32'h0);
      xfer("rd_raw", 32'h10, 4'b0000, 32'h0, 32'hDEAD5678);
      xfer("rd_wrap", 32'h0000_1010, 4'b0000, 32'h0, 32'hDEAD5678);

      xfer("wr_full", 32'h50, 4'b1111, 32'hA1B2C3D4, 32'h0);
      xfer("wr_b2", 32'h50, 4'b0100, 32'h00EE0000, 32'h0);
      xfer("wr_b30", 32'h50, 4'b1001, 32'h99000011, 32'h0);
      xfer("rd_mix", 32'h50, 4'b0000, 32'h0, 32'h99EEC311);
      xfer("rd_mixw", 32'h1050, 4'b0000, 32'h0, 32'h99EEC311);

      backdoor(10'd8, 32'hCAFEF00D);
      @(negedge clk);
      bus.dreq.valid  = 1'b1;
      bus.dreq.addr   = 32'h20;
      bus.dreq.size   = 3'd2;
      bus.dreq.strobe = 4'b1111;
      bus.dreq.data   = 32'hFFFFFFFF;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.dresp.addr_ok) break;
      end
      chk("abort/aok_lat", n, 0);
      @(negedge clk);
      chk("abort/pre_busy", {31'b0, busy}, 1);
      reset = 1'b1;
      #1;
      chk("abort/flags", {bus.dresp.addr_ok, bus.dresp.data_ok, busy}, 0);
      chk("abort/data", bus.dresp.data, 0);
      bus.dreq = '0;
      @(negedge clk);
      reset = 1'b0;
      nreq++;
      xfer("abort_rd", 32'h20, 4'b0000, 32'h0, 32'hCAFEF00D);

      load_en   = 1'b1;
      load_addr = 10'd12;
      load_data = 32'h11223344;
      xfer("coll_wr", 32'h30, 4'b1111, 32'h55667788, 32'h0);
      @(negedge clk);
      load_en = 1'b0;
      xfer("coll_rd", 32'h30, 4'b0000, 32'h0, 32'h55667788);

      repeat (2) @(negedge clk);
      chk("aok_count", n_aok, nreq);
      chk("dok_count", n_dok, nreq - 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
